// File: rtl/rob_ctrl_pkg.sv
// ============================================================================
// Module  : rob_ctrl_pkg
// Brief   : Shared types and constants for the ROB commit controller.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package rob_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_REC_ISSUE = 2'd1,
        ST_REC_HOLD  = 2'd2
    } state_t;

    localparam int STAT_WIDTH = 32;

endpackage : rob_ctrl_pkg

`default_nettype wire

// File: rtl/rob_commit_stats.sv
// ============================================================================
// Module  : rob_commit_stats
// Brief   : Saturating commit and head-stall counters (COMMIT_STATS_EN only).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rob_commit_stats
    import rob_ctrl_pkg::*;
#(
    parameter int INSTR_COUNT = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [INSTR_COUNT-1:0] i_pop,
    input  logic                   i_stall,
    output logic [STAT_WIDTH-1:0]  o_commits,
    output logic [STAT_WIDTH-1:0]  o_stalls
);

    localparam int CNT_W = $clog2(INSTR_COUNT + 1);

    logic [CNT_W-1:0]      w_pop_cnt;
    logic [STAT_WIDTH:0]   w_commit_sum;
    logic [STAT_WIDTH-1:0] r_commits;
    logic [STAT_WIDTH-1:0] r_stalls;

    always_comb begin
        w_pop_cnt = '0;
        for (int i = 0; i < INSTR_COUNT; i++) begin
            w_pop_cnt = w_pop_cnt + CNT_W'(i_pop[i]);
        end
    end

    // One extra bit catches the carry so the counter pins at all-ones.
    assign w_commit_sum = {1'b0, r_commits} + (STAT_WIDTH + 1)'(w_pop_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_commits <= '0;
            r_stalls  <= '0;
        end else begin
            r_commits <= w_commit_sum[STAT_WIDTH] ? '1 : w_commit_sum[STAT_WIDTH-1:0];
            if (i_stall && (r_stalls != '1)) begin
                r_stalls <= r_stalls + 1'b1;
            end
        end
    end

    assign o_commits = r_commits;
    assign o_stalls  = r_stalls;

endmodule : rob_commit_stats

`default_nettype wire

// File: rtl/rob_commit_ctrl.sv
// ============================================================================
// Module  : rob_commit_ctrl
// Brief   : In-order ROB commit, free-list release and flush recovery control.
//           Optional statistics counters enabled by macro COMMIT_STATS_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rob_commit_ctrl
    import rob_ctrl_pkg::*;
#(
    parameter int ROB_DEPTH    = 128,
    parameter int P_ADDR_WIDTH = 7,
    parameter int INSTR_COUNT  = 2,
    parameter int REC_CYCLES   = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [INSTR_COUNT-1:0]              rob_valid,
    input  logic [INSTR_COUNT-1:0]              rob_exec,
    input  logic [INSTR_COUNT*P_ADDR_WIDTH-1:0] rob_ppdst,
    output logic [INSTR_COUNT-1:0]              rob_pop,
    output logic [INSTR_COUNT-1:0]              rel_valid,
    output logic [INSTR_COUNT*P_ADDR_WIDTH-1:0] rel_ppdst,
    input  logic                                rel_ready,
    input  logic                                flush_req,
    input  logic [$clog2(ROB_DEPTH)-1:0]        flush_id,
    output logic                                rec_en,
    output logic [$clog2(ROB_DEPTH)-1:0]        rec_id,
    output logic                                busy
`ifdef COMMIT_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0]               stat_commits,
    output logic [STAT_WIDTH-1:0]               stat_stalls
`endif
);

    localparam int ID_W   = $clog2(ROB_DEPTH);
    localparam int HOLD_W = $clog2(REC_CYCLES + 1);
    localparam logic [HOLD_W-1:0] C_HOLD_INIT = HOLD_W'(REC_CYCLES);
    localparam logic [HOLD_W-1:0] C_HOLD_ONE  = HOLD_W'(1);

    state_t                              r_state;
    state_t                              w_state_nxt;
    logic [HOLD_W-1:0]                   r_hold;
    logic [ID_W-1:0]                     r_rec_id;
    logic [INSTR_COUNT-1:0]              r_rel_valid;
    logic [INSTR_COUNT*P_ADDR_WIDTH-1:0] r_rel_ppdst;
    logic [INSTR_COUNT-1:0]              w_rel_valid_nxt;
    logic [INSTR_COUNT*P_ADDR_WIDTH-1:0] w_rel_ppdst_nxt;
    logic [INSTR_COUNT-1:0]              w_pop;
    logic                                w_rel_free;
    logic                                w_can_commit;
    logic                                w_chain;

    // The release register can take a new bundle when it is empty or draining.
    assign w_rel_free   = ~(|r_rel_valid) | rel_ready;
    assign w_can_commit = rst_n & (r_state == ST_RUN) & ~flush_req & w_rel_free;

    always_comb begin
        w_pop   = '0;
        w_chain = w_can_commit;
        for (int i = 0; i < INSTR_COUNT; i++) begin
            w_chain  = w_chain & rob_valid[i] & rob_exec[i];
            w_pop[i] = w_chain;
        end
    end

    always_comb begin
        w_rel_valid_nxt = '0;
        w_rel_ppdst_nxt = '0;
        for (int i = 0; i < INSTR_COUNT; i++) begin
            if (w_pop[i]) begin
                w_rel_ppdst_nxt[i*P_ADDR_WIDTH +: P_ADDR_WIDTH] = rob_ppdst[i*P_ADDR_WIDTH +: P_ADDR_WIDTH];
                // Physical register 0 marks an instruction without a destination.
                w_rel_valid_nxt[i] = |rob_ppdst[i*P_ADDR_WIDTH +: P_ADDR_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rel_valid <= '0;
            r_rel_ppdst <= '0;
        end else if (w_rel_free) begin
            r_rel_valid <= w_rel_valid_nxt;
            r_rel_ppdst <= w_rel_ppdst_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:       if (flush_req) w_state_nxt = ST_REC_ISSUE;
            ST_REC_ISSUE: w_state_nxt = ST_REC_HOLD;
            ST_REC_HOLD:  if (r_hold <= C_HOLD_ONE) w_state_nxt = ST_RUN;
            default:      w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold   <= '0;
            r_rec_id <= '0;
        end else begin
            if (r_state == ST_REC_ISSUE) begin
                r_hold <= C_HOLD_INIT;
            end else if ((r_state == ST_REC_HOLD) && (r_hold != '0)) begin
                r_hold <= r_hold - C_HOLD_ONE;
            end
            if ((r_state == ST_RUN) && flush_req) begin
                r_rec_id <= flush_id;
            end
        end
    end

    assign rob_pop   = w_pop;
    assign rel_valid = r_rel_valid;
    assign rel_ppdst = r_rel_ppdst;
    assign rec_en    = (r_state == ST_REC_ISSUE);
    assign rec_id    = r_rec_id;
    assign busy      = (r_state != ST_RUN);

`ifdef COMMIT_STATS_EN
    logic w_stall;
    assign w_stall = rob_valid[0] & rob_exec[0] & ~w_pop[0];

    rob_commit_stats #(
        .INSTR_COUNT (INSTR_COUNT)
    ) u_stats (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_pop     (w_pop),
        .i_stall   (w_stall),
        .o_commits (stat_commits),
        .o_stalls  (stat_stalls)
    );
`endif

endmodule : rob_commit_ctrl

`default_nettype wire

// File: tb/tb_rob_commit_ctrl.sv
// ============================================================================
// Module  : tb_rob_commit_ctrl
// Brief   : Directed self-checking bench for rob_commit_ctrl (2 slots, 2 hold).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rob_commit_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  rob_valid = '0;
    logic [1:0]  rob_exec = '0;
    logic [13:0] rob_ppdst = '0;
    logic [1:0]  rob_pop;
    logic [1:0]  rel_valid;
    logic [13:0] rel_ppdst;
    logic        rel_ready = 1'b1;
    logic        flush_req = 1'b0;
    logic [6:0]  flush_id = '0;
    logic        rec_en;
    logic [6:0]  rec_id;
    logic        busy;
`ifdef COMMIT_STATS_EN
    logic [31:0] stat_commits;
    logic [31:0] stat_stalls;
`endif

    int checks   = 0;
    int failures = 0;

    rob_commit_ctrl #(
        .ROB_DEPTH    (128),
        .P_ADDR_WIDTH (7),
        .INSTR_COUNT  (2),
        .REC_CYCLES   (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rob_valid (rob_valid),
        .rob_exec  (rob_exec),
        .rob_ppdst (rob_ppdst),
        .rob_pop   (rob_pop),
        .rel_valid (rel_valid),
        .rel_ppdst (rel_ppdst),
        .rel_ready (rel_ready),
        .flush_req (flush_req),
        .flush_id  (flush_id),
        .rec_en    (rec_en),
        .rec_id    (rec_id),
        .busy      (busy)
`ifdef COMMIT_STATS_EN
        ,
        .stat_commits (stat_commits),
        .stat_stalls  (stat_stalls)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick(); tick();
        check("rst_pop", rob_pop, 2'b00);
        check("rst_rel_valid", rel_valid, 2'b00);
        check("rst_rel_ppdst", rel_ppdst, 14'd0);
        check("rst_rec_en", rec_en, 1'b0);
        check("rst_rec_id", rec_id, 7'd0);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        tick();

        // Full two-slot commit, slot0=5 slot1=9
        rob_valid = 2'b11; rob_exec = 2'b11; rob_ppdst = {7'd9, 7'd5}; rel_ready = 1'b1;
        #1 check("pop_both", rob_pop, 2'b11);
        tick();
        rob_valid = 2'b00; rob_exec = 2'b00;
        #1 check("rel_valid_both", rel_valid, 2'b11);
        check("rel_ppdst_both", rel_ppdst, {7'd9, 7'd5});
        check("pop_idle", rob_pop, 2'b00);

        // In-order commit stops at first unexecuted slot
        rob_valid = 2'b11; rob_exec = 2'b10;
        #1 check("pop_head_unexec", rob_pop, 2'b00);
        rob_exec = 2'b01;
        #1 check("pop_head_only", rob_pop, 2'b01);
        tick();
        rob_valid = 2'b00; rob_exec = 2'b00;
        #1 check("rel_valid_head", rel_valid, 2'b01);
        check("rel_ppdst_head", rel_ppdst, {7'd0, 7'd5});

        // ppdst 0 in slot0: popped but not released
        rob_valid = 2'b11; rob_exec = 2'b11; rob_ppdst = {7'd12, 7'd0};
        #1 check("pop_zero_dst", rob_pop, 2'b11);
        tick();
        rob_valid = 2'b00; rob_exec = 2'b00;
        #1 check("rel_valid_zero_dst", rel_valid, 2'b10);
        check("rel_ppdst_zero_dst", rel_ppdst, {7'd12, 7'd0});

        // Backpressure from free list
        rob_valid = 2'b11; rob_exec = 2'b11; rob_ppdst = {7'd9, 7'd5};
        tick();
        rel_ready = 1'b0; rob_ppdst = {7'd4, 7'd3};
        for (int k = 0; k < 3; k++) begin
            #1 check("bp_pop", rob_pop, 2'b00);
            check("bp_rel_valid", rel_valid, 2'b11);
            check("bp_rel_ppdst", rel_ppdst, {7'd9, 7'd5});
            tick();
        end
        rel_ready = 1'b1;
        #1 check("bp_resume_pop", rob_pop, 2'b11);
        tick();
        rob_valid = 2'b00; rob_exec = 2'b00;
        #1 check("bp_reload_valid", rel_valid, 2'b11);
        check("bp_reload_ppdst", rel_ppdst, {7'd4, 7'd3});
        tick();
        check("rel_cleared", rel_valid, 2'b00);

        // Flush and recovery
        rob_valid = 2'b11; rob_exec = 2'b11; rob_ppdst = {7'd9, 7'd5};
        flush_req = 1'b1; flush_id = 7'd127;
        #1 check("flush_pop_suppressed", rob_pop, 2'b00);
        check("flush_busy_low", busy, 1'b0);
        tick();
        flush_req = 1'b0; flush_id = 7'd0;
        #1 check("issue_rec_en", rec_en, 1'b1);
        check("issue_rec_id", rec_id, 7'd127);
        check("issue_busy", busy, 1'b1);
        check("issue_pop", rob_pop, 2'b00);
        check("issue_rel_valid", rel_valid, 2'b00);
        tick();
        check("hold1_rec_en", rec_en, 1'b0);
        check("hold1_busy", busy, 1'b1);
        flush_req = 1'b1; flush_id = 7'd5;
        #1 check("hold1_pop", rob_pop, 2'b00);
        tick();
        flush_req = 1'b0;
        check("hold2_busy", busy, 1'b1);
        check("hold2_rec_en", rec_en, 1'b0);
        tick();
        check("run_busy", busy, 1'b0);
        check("run_pop", rob_pop, 2'b11);
        check("run_rec_id_kept", rec_id, 7'd127);
        tick();
        rob_valid = 2'b00; rob_exec = 2'b00;
        #1 check("no_second_rec_en", rec_en, 1'b0);
        check("no_second_busy", busy, 1'b0);
        check("run_rel_valid", rel_valid, 2'b11);
        tick();

        // Reset during REC_HOLD
        flush_req = 1'b1; flush_id = 7'd10;
        tick();
        flush_req = 1'b0;
        check("f2_rec_en", rec_en, 1'b1);
        tick();
        check("f2_hold_busy", busy, 1'b1);
        rob_valid = 2'b11; rob_exec = 2'b11;
        rst_n = 1'b0;
        #1 check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_rec_en", rec_en, 1'b0);
        check("mid_rst_rec_id", rec_id, 7'd0);
        check("mid_rst_pop", rob_pop, 2'b00);
        check("mid_rst_rel_valid", rel_valid, 2'b00);
        check("mid_rst_rel_ppdst", rel_ppdst, 14'd0);
        tick();
        rst_n = 1'b1; rob_valid = 2'b00; rob_exec = 2'b00;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("post_rst_rec_en", rec_en, 1'b0);
            check("post_rst_busy", busy, 1'b0);
        end
        rob_valid = 2'b11; rob_exec = 2'b11;
        #1 check("post_rst_pop", rob_pop, 2'b11);
        tick();
        rob_valid = 2'b00; rob_exec = 2'b00;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_rob_commit_ctrl

`default_nettype wire

// File: doc/rob_commit_ctrl.md
ROB_COMMIT_CTRL -- requirements
Module: rob_commit_ctrl

Interface
REQ-001 SHALL have parameter ROB_DEPTH, default 128, number of ROB entries.
REQ-002 SHALL have parameter P_ADDR_WIDTH, default 7, physical register index width.
REQ-003 SHALL have parameter INSTR_COUNT, default 2, commit/release slots per cycle.
REQ-004 SHALL have parameter REC_CYCLES, default 2, post-recovery hold cycles (>=1).
REQ-005 clk  in  1  sole clock; all state on rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 rob_valid  in  INSTR_COUNT  thermometer of occupied head slots from ROB.
REQ-008 rob_exec  in  INSTR_COUNT  executed flag per head slot.
REQ-009 rob_ppdst  in  INSTR_COUNT x P_ADDR_WIDTH  previous physical dst per head slot.
REQ-010 rob_pop  out  INSTR_COUNT  thermometer pop to ROB.
REQ-011 rel_valid  out  INSTR_COUNT  per-slot free-list release valid.
REQ-012 rel_ppdst  out  INSTR_COUNT x P_ADDR_WIDTH  register released per slot.
REQ-013 rel_ready  in  1  free list accepts entire rel_* bundle this cycle.
REQ-014 flush_req  in  1  one-cycle mispredict pulse.
REQ-015 flush_id  in  clog2(ROB_DEPTH)  ROB id of first squashed entry.
REQ-016 rec_en  out  1  recovery pulse to ROB.
REQ-017 rec_id  out  clog2(ROB_DEPTH)  new ROB tail.
REQ-018 busy  out  1  high while not in RUN.

Function
REQ-019 SHALL implement states RUN, REC_ISSUE, REC_HOLD; reset state RUN.
REQ-020 rob_pop[i] SHALL be 1 iff state==RUN, !flush_req, release register free-or-draining (!any rel_valid or rel_ready), and rob_valid[k]&&rob_exec[k] for all k<=i; result is always thermometer.
REQ-021 Committing stops at first unexecuted or invalid slot; no out-of-order commit.
REQ-022 Popped slots SHALL load the release register next edge: rel_valid[i]=rob_pop[i]&&(rob_ppdst[i]!=0), rel_ppdst[i]=rob_ppdst[i]; latency exactly 1 cycle.
REQ-023 ppdst value 0 SHALL mean no destination; slot popped but never released.
REQ-024 rel_* SHALL hold stable while any rel_valid is high and rel_ready is low; cleared after acceptance unless reloaded same edge.
REQ-025 flush_req in RUN SHALL suppress that cycle's pops, go to REC_ISSUE, register rec_id=flush_id.
REQ-026 REC_ISSUE SHALL assert rec_en for exactly one cycle, then enter REC_HOLD with hold counter=REC_CYCLES.
REQ-027 REC_HOLD SHALL decrement counter each cycle; return to RUN the cycle after it reaches 1.
REQ-028 flush_req outside RUN SHALL be ignored.
REQ-029 Pending release bundle SHALL survive recovery and still be handshaken (registers already retired).
REQ-030 flush_id SHALL pass unmodified (range 0..ROB_DEPTH-1; wrap handled by ROB).
REQ-031 busy SHALL equal (state!=RUN), registered.

Reset
REQ-032 On rst_n low: state=RUN, rob_pop=0, rel_valid=0, rel_ppdst=0, rec_en=0, rec_id=0, busy=0, hold counter=0, stats counters=0.
REQ-033 Reset mid-recovery SHALL abandon it; no rec_en after deassertion.

Configuration
REQ-034 With COMMIT_STATS_EN defined: outputs stat_commits (32b, += popcount(rob_pop) per cycle, saturating) and stat_stalls (32b, +1 when rob_valid[0]&&rob_exec[0] but rob_pop[0]==0), both wrap-free saturating.
REQ-035 Without COMMIT_STATS_EN: those ports and counters absent; all other behaviour identical.

Structure
REQ-036 Package rob_ctrl_pkg SHALL hold the state enum type and stats counter width constant.
REQ-037 Stats counters SHALL live in sub-module rob_commit_stats, instantiated only under COMMIT_STATS_EN.

Verification (INSTR_COUNT=2, REC_CYCLES=2)
REQ-038 valid=11, exec=11, ppdst={5,9}, rel_ready=1 -> rob_pop=11; next cycle rel_valid=11, rel_ppdst={5,9}.
REQ-039 valid=11, exec=10 (slot0 not executed) -> rob_pop=00; exec=01 -> rob_pop=01.
REQ-040 Pop with ppdst={0,12} -> rel_valid=10 (slot1 only), both entries popped.
REQ-041 rel_valid=11, rel_ready=0 for 3 cycles -> rob_pop=00, rel_* stable; rel_ready=1 -> pops resume same cycle.
REQ-042 flush_req, flush_id=127 in RUN -> pop 00 that cycle; rec_en=1, rec_id=127 next cycle; busy high 3 cycles; RUN after; second flush_req during REC_HOLD ignored.
REQ-043 rst_n low during REC_HOLD -> all outputs 0, state RUN, no rec_en after release.
